// File: rtl/fp_pkg.sv
// Shared definitions for the floating-point multiplier: format defaults, operand classes,
// flag bit positions and the canonical quiet NaN.
package fp_pkg;

  localparam int unsigned ExpWDefault = 8;
  localparam int unsigned ManWDefault = 23;

  typedef enum logic [2:0] {
    ClsZero,
    ClsNorm,
    ClsInf,
    ClsQNan,
    ClsSNan
  } fp_class_e;

  localparam int unsigned FlagInvalid   = 3;
  localparam int unsigned FlagOverflow  = 2;
  localparam int unsigned FlagUnderflow = 1;
  localparam int unsigned FlagInexact   = 0;

  localparam logic [31:0] CanonNanSingle = 32'h7FC0_0000;

  function automatic int fp_bias(int unsigned exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

endpackage

// File: rtl/fp_round_pack.sv
// Final stage: normalise the significand product, round to nearest even, detect
// overflow/underflow and pack the result word with its flags.
module fp_round_pack import fp_pkg::*; #(
  parameter int unsigned EXP_W = ExpWDefault,
  parameter int unsigned MAN_W = ManWDefault
) (
  input  logic                   sign_i,
  input  logic signed [EXP_W+1:0] exp_i,
  input  logic [2*MAN_W+1:0]     prod_i,
  input  logic [2:0]             cls_i,
  input  logic                   invalid_i,
  output logic [EXP_W+MAN_W:0]   res_o,
  output logic [3:0]             flags_o
);

  localparam int unsigned W  = 1 + EXP_W + MAN_W;
  localparam int unsigned PW = 2 * (MAN_W + 1);
  localparam logic signed [EXP_W+1:0] ExpMax = {2'b00, {EXP_W{1'b1}}};

  logic [PW-1:0]           norm;
  logic signed [EXP_W+1:0] exp_n;
  logic signed [EXP_W+1:0] exp_f;
  logic [MAN_W:0]          mant;
  logic                    guard;
  logic                    rnd;
  logic                    sticky;
  logic                    round_up;
  logic [MAN_W+1:0]        mant_r;
  logic [MAN_W-1:0]        frac;

  always_comb begin
    // Product lies in [1,4); a set top bit means one right shift is needed.
    norm     = prod_i[PW-1] ? prod_i : {prod_i[PW-2:0], 1'b0};
    exp_n    = exp_i + {{(EXP_W+1){1'b0}}, prod_i[PW-1]};
    mant     = norm[PW-1 -: MAN_W+1];
    guard    = norm[PW-MAN_W-2];
    rnd      = norm[PW-MAN_W-3];
    sticky   = |norm[PW-MAN_W-4:0];
    round_up = guard & (rnd | sticky | mant[0]);
    mant_r   = {1'b0, mant} + {{(MAN_W+1){1'b0}}, round_up};
    exp_f    = exp_n + {{(EXP_W+1){1'b0}}, mant_r[MAN_W+1]};
    frac     = mant_r[MAN_W+1] ? mant_r[MAN_W:1] : mant_r[MAN_W-1:0];

    res_o   = '0;
    flags_o = '0;
    unique case (fp_class_e'(cls_i))
      ClsZero: res_o = {sign_i, {(W-1){1'b0}}};
      ClsInf:  res_o = {sign_i, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      ClsQNan, ClsSNan: begin
        res_o                = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
        flags_o[FlagInvalid] = invalid_i;
      end
      default: begin
        if (exp_f >= ExpMax) begin
          res_o                 = {sign_i, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
          flags_o[FlagOverflow] = 1'b1;
          flags_o[FlagInexact]  = 1'b1;
        end else if (exp_f[EXP_W+1] || (exp_f == '0)) begin
          res_o                  = {sign_i, {(W-1){1'b0}}};
          flags_o[FlagUnderflow] = 1'b1;
          flags_o[FlagInexact]   = 1'b1;
        end else begin
          res_o                = {sign_i, exp_f[EXP_W-1:0], frac};
          flags_o[FlagInexact] = guard | rnd | sticky;
        end
      end
    endcase
  end

endmodule

// File: rtl/fp_mul_pipe.sv
// Three-stage pipelined floating-point multiplier with valid/ready handshakes:
// S1 unpack/classify, S2 significand multiply, S3 normalise/round/pack.
module fp_mul_pipe import fp_pkg::*; #(
  parameter int unsigned EXP_W = ExpWDefault,
  parameter int unsigned MAN_W = ManWDefault
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [EXP_W+MAN_W:0] IN1,
  input  logic [EXP_W+MAN_W:0] IN2,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [EXP_W+MAN_W:0] OUT,
  output logic [3:0]           flags
);

  localparam int unsigned W  = 1 + EXP_W + MAN_W;
  localparam int unsigned SW = MAN_W + 1;
  localparam int unsigned PW = 2 * SW;
  localparam logic signed [EXP_W+1:0] Bias = (EXP_W+2)'(fp_bias(EXP_W));
  localparam logic [EXP_W-1:0] ExpOnes = '1;

  function automatic fp_class_e classify(logic [W-1:0] x);
    logic [EXP_W-1:0] e;
    logic [MAN_W-1:0] f;
    e = x[W-2 -: EXP_W];
    f = x[MAN_W-1:0];
    if (e == '0) return ClsZero;  // subnormals flush to zero
    if (e == ExpOnes) return (f == '0) ? ClsInf : (f[MAN_W-1] ? ClsQNan : ClsSNan);
    return ClsNorm;
  endfunction

  logic adv;
  assign adv      = out_ready | ~out_valid;
  assign in_ready = adv & ~rst;

  // S1 next-state
  fp_class_e               c1, c2, s1_cls_d;
  logic                    s1_inv_d;
  logic signed [EXP_W+1:0] s1_exp_d;
  logic                    nan_any, inf_any, zero_any, inf_zero;

  always_comb begin
    c1       = classify(IN1);
    c2       = classify(IN2);
    nan_any  = (c1 inside {ClsQNan, ClsSNan}) || (c2 inside {ClsQNan, ClsSNan});
    inf_any  = (c1 == ClsInf) || (c2 == ClsInf);
    zero_any = (c1 == ClsZero) || (c2 == ClsZero);
    inf_zero = inf_any && zero_any;
    s1_inv_d = (c1 == ClsSNan) || (c2 == ClsSNan) || (inf_zero && !nan_any);
    if (nan_any || inf_zero) s1_cls_d = ClsQNan;
    else if (inf_any)        s1_cls_d = ClsInf;
    else if (zero_any)       s1_cls_d = ClsZero;
    else                     s1_cls_d = ClsNorm;
    s1_exp_d = $signed({2'b00, IN1[W-2 -: EXP_W]}) + $signed({2'b00, IN2[W-2 -: EXP_W]}) - Bias;
  end

  logic                    s1_valid_q, s2_valid_q, s3_valid_q;
  logic                    s1_sign_q, s2_sign_q;
  logic signed [EXP_W+1:0] s1_exp_q, s2_exp_q;
  logic [SW-1:0]           s1_ma_q, s1_mb_q;
  fp_class_e               s1_cls_q, s2_cls_q;
  logic                    s1_inv_q, s2_inv_q;
  logic [PW-1:0]           s2_prod_q, s2_prod_d;
  logic [W-1:0]            s3_res_q, s3_res_d;
  logic [3:0]              s3_flags_q, s3_flags_d;

  assign s2_prod_d = PW'(s1_ma_q) * PW'(s1_mb_q);

  fp_round_pack #(
    .EXP_W(EXP_W),
    .MAN_W(MAN_W)
  ) u_round_pack (
    .sign_i   (s2_sign_q),
    .exp_i    (s2_exp_q),
    .prod_i   (s2_prod_q),
    .cls_i    (s2_cls_q),
    .invalid_i(s2_inv_q),
    .res_o    (s3_res_d),
    .flags_o  (s3_flags_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s3_valid_q <= 1'b0;
      s3_res_q   <= '0;
      s3_flags_q <= '0;
    end else if (adv) begin
      s1_valid_q <= in_valid;
      s2_valid_q <= s1_valid_q;
      s3_valid_q <= s2_valid_q;
      s3_res_q   <= s3_res_d;
      s3_flags_q <= s3_flags_d;
    end
  end

  // Datapath registers carry no reset; only the valid bits qualify them.
  always_ff @(posedge clk) begin
    if (adv) begin
      s1_sign_q <= IN1[W-1] ^ IN2[W-1];
      s1_exp_q  <= s1_exp_d;
      s1_ma_q   <= {1'b1, IN1[MAN_W-1:0]};
      s1_mb_q   <= {1'b1, IN2[MAN_W-1:0]};
      s1_cls_q  <= s1_cls_d;
      s1_inv_q  <= s1_inv_d;
      s2_sign_q <= s1_sign_q;
      s2_exp_q  <= s1_exp_q;
      s2_prod_q <= s2_prod_d;
      s2_cls_q  <= s1_cls_q;
      s2_inv_q  <= s1_inv_q;
    end
  end

  assign out_valid = s3_valid_q;
  assign OUT       = s3_res_q;
  assign flags     = s3_flags_q;

endmodule
